// File: rtl/alu_issue.sv
// Issue sequencer for an external falling-edge ALU: runs 1-3 passes per
// request (32-bit add/sub via lo, hi and optional carry/borrow correction).
// Ports: clk/rst; req_* request handshake and operands; rsp_* response
// handshake and result/flags; alu_a/alu_b/alu_op/alu_enflags drive the ALU,
// alu_s/alu_flags return its result sampled at the end of each pass.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic        req_wide,
    input  logic        req_flags,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [15:0] req_a_hi,
    input  logic [15:0] req_b_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_s,
    output logic [15:0] rsp_s_hi,
    output logic [3:0]  rsp_flags,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_enflags,
    input  logic [15:0] alu_s,
    input  logic [3:0]  alu_flags
);

    // EXEC is the first cycle of a pass, DECIDE the second; the result is
    // sampled on the edge leaving DECIDE, where the next pass is chosen.
    typedef enum logic [1:0] {IDLE, EXEC, DECIDE, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  pass, pass_nx;
    logic        carry, carry_nx;
    logic        wide, wide_nx;
    logic        flg, flg_nx;
    logic [15:0] a_lo, a_lo_nx, b_lo, b_lo_nx;
    logic [15:0] a_hi, a_hi_nx, b_hi, b_hi_nx;
    logic        req_ready_nx, rsp_valid_nx, alu_enflags_nx;
    logic [15:0] rsp_s_nx, rsp_s_hi_nx, alu_a_nx, alu_b_nx;
    logic [3:0]  rsp_flags_nx;
    logic [2:0]  alu_op_nx;
    logic        last;

    // Final pass: narrow op, hi pass without correction, or correction pass.
    assign last = (pass == 2'd0 && !wide) ||
                  (pass == 2'd1 && !carry) ||
                  (pass == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid) state_nx = EXEC;
            EXEC:    state_nx = DECIDE;
            DECIDE:  state_nx = last ? RESP : EXEC;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pass_nx        = pass;
        carry_nx       = carry;
        wide_nx        = wide;
        flg_nx         = flg;
        a_lo_nx        = a_lo;
        b_lo_nx        = b_lo;
        a_hi_nx        = a_hi;
        b_hi_nx        = b_hi;
        rsp_valid_nx   = rsp_valid;
        rsp_s_nx       = rsp_s;
        rsp_s_hi_nx    = rsp_s_hi;
        rsp_flags_nx   = rsp_flags;
        alu_a_nx       = alu_a;
        alu_b_nx       = alu_b;
        alu_op_nx      = alu_op;
        alu_enflags_nx = alu_enflags;
        req_ready_nx   = (state_nx == IDLE);
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    wide_nx        = req_wide && (req_op[2:1] == 2'b00);
                    flg_nx         = req_flags;
                    a_lo_nx        = req_a;
                    b_lo_nx        = req_b;
                    a_hi_nx        = req_a_hi;
                    b_hi_nx        = req_b_hi;
                    pass_nx        = 2'd0;
                    carry_nx       = 1'b0;
                    rsp_s_hi_nx    = 16'h0000;
                    alu_a_nx       = req_a;
                    alu_b_nx       = req_b;
                    alu_op_nx      = req_op;
                    alu_enflags_nx = req_flags &&
                        !(req_wide && (req_op[2:1] == 2'b00));
                end
            end
            DECIDE: begin
                rsp_flags_nx = alu_flags;
                if (pass == 2'd0) begin
                    rsp_s_nx = alu_s;
                    if (wide) begin
                        carry_nx = alu_op[0] ? (a_lo < b_lo)
                                             : (alu_s < a_lo);
                        alu_a_nx       = a_hi;
                        alu_b_nx       = b_hi;
                        alu_enflags_nx = flg && !carry_nx;
                        pass_nx        = 2'd1;
                    end
                end else if (pass == 2'd1) begin
                    if (carry) begin
                        alu_a_nx       = alu_s;
                        alu_b_nx       = 16'h0001;
                        alu_enflags_nx = flg;
                        pass_nx        = 2'd2;
                    end else begin
                        rsp_s_hi_nx = alu_s;
                    end
                end else begin
                    rsp_s_hi_nx = alu_s;
                end
                if (last) begin
                    rsp_valid_nx   = 1'b1;
                    alu_enflags_nx = 1'b0;
                end
            end
            RESP: if (rsp_ready) rsp_valid_nx = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass        <= 2'd0;
            carry       <= 1'b0;
            wide        <= 1'b0;
            flg         <= 1'b0;
            a_lo        <= 16'h0000;
            b_lo        <= 16'h0000;
            a_hi        <= 16'h0000;
            b_hi        <= 16'h0000;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_s       <= 16'h0000;
            rsp_s_hi    <= 16'h0000;
            rsp_flags   <= 4'b0000;
            alu_a       <= 16'h0000;
            alu_b       <= 16'h0000;
            alu_op      <= 3'b000;
            alu_enflags <= 1'b0;
        end else begin
            pass        <= pass_nx;
            carry       <= carry_nx;
            wide        <= wide_nx;
            flg         <= flg_nx;
            a_lo        <= a_lo_nx;
            b_lo        <= b_lo_nx;
            a_hi        <= a_hi_nx;
            b_hi        <= b_hi_nx;
            req_ready   <= req_ready_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_s       <= rsp_s_nx;
            rsp_s_hi    <= rsp_s_hi_nx;
            rsp_flags   <= rsp_flags_nx;
            alu_a       <= alu_a_nx;
            alu_b       <= alu_b_nx;
            alu_op      <= alu_op_nx;
            alu_enflags <= alu_enflags_nx;
        end
    end

endmodule
